// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with split-transaction parking and resume priority.
// Define ARB_ROUND_ROBIN_EN for a round-robin base policy; otherwise master 0 has fixed priority.
module bus_arbiter #(
    parameter int TURNAROUND = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] M_HOLD,
    input  logic       S_SPLIT,
    input  logic       S_RESUME,
    input  logic       S_RESUME_ID,
    output logic [1:0] M_GRANT,
    output logic [1:0] M_SPLIT,
    output logic       BUS_SEL,
    output logic       BUS_BSY
);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [1:0] grant_q, split_q, split_d, rp_q, rp_d;
    logic [1:0] elig, res_v, park_v, gnt_v;
    logic       sel_q, win, base, arb;

    function automatic logic [1:0] oh(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    assign base = ~last_q;
`else
    assign base = 1'b0;
`endif

    always_comb begin
        elig   = M_HOLD & ~split_q;
        win    = (rp_q[0] & elig[0]) ? 1'b0 : (rp_q[1] & elig[1]) ? 1'b1 : (&elig) ? base : ~elig[0];
        arb    = (state_q == IDLE) || (state_q == GAP && cnt_q == 3'd0);
        res_v  = (S_RESUME && split_q[S_RESUME_ID]) ? oh(S_RESUME_ID) : 2'b00;
        park_v = (state_q == OWN && M_HOLD[sel_q] && S_SPLIT) ? oh(sel_q) : 2'b00;
        gnt_v  = (arb && |elig) ? oh(win) : 2'b00;
        // a dropped M_HOLD aborts both the park and any pending resume priority
        split_d = M_HOLD & ((split_q & ~res_v) | park_v);
        rp_d    = M_HOLD & (rp_q | res_v) & ~gnt_v;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            split_q <= '0;
            rp_q    <= '0;
            sel_q   <= 1'b0;
        end else begin
            split_q <= split_d;
            rp_q    <= rp_d;
            if (state_q == OWN) begin
                if (!M_HOLD[sel_q] || S_SPLIT) begin
                    state_q <= GAP;
                    grant_q <= '0;
                    cnt_q   <= 3'(TURNAROUND - 1);
                end
            end else if (!arb) begin
                cnt_q <= cnt_q - 3'd1;
            end else if (|elig) begin
                state_q <= OWN;
                grant_q <= gnt_v;
                sel_q   <= win;
            end else begin
                state_q <= IDLE;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last_q <= 1'b1;
        else if (arb && |elig)
            last_q <= win;
    end
`endif

    assign M_GRANT = grant_q;
    assign M_SPLIT = split_q;
    assign BUS_SEL = sel_q;
    assign BUS_BSY = |grant_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: random stimulus against an owner/park/priority model, for TURNAROUND 1 and 3.
module tb_bus_arbiter;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] M_HOLD = 2'b00;
    logic       S_SPLIT = 1'b0;
    logic       S_RESUME = 1'b0;
    logic       S_RESUME_ID = 1'b0;
    logic [1:0] g1, s1, g3, s3;
    logic       sel1, bsy1, sel3, bsy3;

    int         vectors = 0;
    int         miscompares = 0;
    int         m_owner[2];
    int         m_wait[2];
    int         m_last[2];
    int         m_sel[2];
    logic [1:0] m_park[2];
    logic [1:0] m_rp[2];

    bus_arbiter u_dut (
        .CLK(CLK), .RST(RST), .M_HOLD(M_HOLD), .S_SPLIT(S_SPLIT),
        .S_RESUME(S_RESUME), .S_RESUME_ID(S_RESUME_ID),
        .M_GRANT(g1), .M_SPLIT(s1), .BUS_SEL(sel1), .BUS_BSY(bsy1)
    );

    bus_arbiter #(.TURNAROUND(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .M_HOLD(M_HOLD), .S_SPLIT(S_SPLIT),
        .S_RESUME(S_RESUME), .S_RESUME_ID(S_RESUME_ID),
        .M_GRANT(g3), .M_SPLIT(s3), .BUS_SEL(sel3), .BUS_BSY(bsy3)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b ({grant,split,sel,bsy})", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_wait[k]  = 0;
            m_last[k]  = 1;
            m_sel[k]   = 0;
            m_park[k]  = 2'b00;
            m_rp[k]    = 2'b00;
        end
    endtask

    function automatic logic [5:0] expected(input int k);
        logic [1:0] g;
        g = (m_owner[k] < 0) ? 2'b00 : (m_owner[k] == 1) ? 2'b10 : 2'b01;
        return {g, m_park[k], m_sel[k] == 1, m_owner[k] >= 0};
    endfunction

    function automatic int pick(input int k, input logic [1:0] e);
        if (m_rp[k][0] && e[0]) return 0;
        if (m_rp[k][1] && e[1]) return 1;
        if (e == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            return 1 - m_last[k];
`else
            return 0;
`endif
        end
        return e[0] ? 0 : 1;
    endfunction

    // Advance model k across one rising edge using the currently driven inputs.
    task automatic step(input int k);
        logic [1:0] e;
        logic       res;
        int         w;
        e   = M_HOLD & ~m_park[k];
        res = S_RESUME && m_park[k][S_RESUME_ID];
        if (m_owner[k] >= 0) begin
            if (!M_HOLD[m_owner[k]] || S_SPLIT) begin
                if (M_HOLD[m_owner[k]]) m_park[k][m_owner[k]] = 1'b1;
                m_owner[k] = -1;
                m_wait[k]  = (k == 1) ? 2 : 0;
            end
        end else if (m_wait[k] > 0) begin
            m_wait[k]--;
        end else if (e != 2'b00) begin
            w = pick(k, e);
            m_owner[k]   = w;
            m_sel[k]     = w;
            m_last[k]    = w;
            m_rp[k][w]   = 1'b0;
        end
        if (res) begin
            m_park[k][S_RESUME_ID] = 1'b0;
            m_rp[k][S_RESUME_ID]   = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (!M_HOLD[i]) begin
                m_park[k][i] = 1'b0;
                m_rp[k][i]   = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        #3;
        check("reset_ta1", {g1, s1, sel1, bsy1}, expected(0));
        check("reset_ta3", {g3, s3, sel3, bsy3}, expected(1));
        @(negedge CLK);
        RST = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(9) == 0) M_HOLD[0] = ~M_HOLD[0];
            if ($urandom_range(9) == 0) M_HOLD[1] = ~M_HOLD[1];
            S_SPLIT     = ($urandom_range(5) == 0);
            S_RESUME    = ($urandom_range(4) == 0);
            S_RESUME_ID = 1'($urandom_range(1));
            step(0);
            step(1);
            @(negedge CLK);
            check("ta1", {g1, s1, sel1, bsy1}, expected(0));
            check("ta3", {g3, s3, sel3, bsy3}, expected(1));
            if (n % 700 == 350) begin
                #2 RST = 1'b1;
                #1;
                check("async_rst_ta1", {g1, s1, sel1, bsy1}, 6'b000000);
                check("async_rst_ta3", {g3, s3, sel3, bsy3}, 6'b000000);
                #1 RST = 1'b0;
                model_reset();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
